// File: rtl/exu_wbck_arb.sv
// exu_wbck_arb: multi-source writeback arbiter feeding the register-file write port.
// Selects one of NCH valid/ready writeback channels per cycle and registers it into
// a single output stage. Writes to x0 complete their handshake but are not forwarded.
// Compile-time option: define WBCK_ROUNDROBIN_EN for round-robin arbitration with a
// grant pointer; when undefined, fixed priority applies (channel 0 highest).
module exu_wbck_arb #(
  parameter int unsigned NCH = 3,
  parameter int unsigned DW  = 32,
  parameter int unsigned AW  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    wbck_i_valid,
  output logic [NCH-1:0]    wbck_i_ready,
  input  logic [NCH*DW-1:0] wbck_i_wdat,
  input  logic [NCH*AW-1:0] wbck_i_rdidx,
  output logic              rf_wbck_o_ena,
  input  logic              rf_wbck_o_ready,
  output logic [DW-1:0]     rf_wbck_o_wdat,
  output logic [AW-1:0]     rf_wbck_o_rdidx
);

  localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;

  // Output stage
  logic           r_o_vld;
  logic [DW-1:0]  r_o_wdat;
  logic [AW-1:0]  r_o_rdidx;

  // Arbitration
  logic           w_free;
  logic           w_any;
  logic           w_acc;
  logic           w_found;
  logic           w_gnt_nz;
  logic [NCH-1:0] w_req;
  logic [NCH-1:0] w_gnt_oh;
  logic [DW-1:0]  w_gnt_wdat;
  logic [AW-1:0]  w_gnt_rdidx;

  // The stage can take a new write when empty or when it drains this cycle
  assign w_free = ~r_o_vld | rf_wbck_o_ready;
  assign w_any  = |wbck_i_valid;
  // Nothing is accepted while reset is asserted
  assign w_acc  = w_free & w_any & ~rst;

`ifdef WBCK_ROUNDROBIN_EN
  logic [PW-1:0]  r_ptr;
  logic [PW-1:0]  w_gnt_idx;
  logic [NCH-1:0] w_hi;

  // Requests at or above ptr take precedence; fall back to the full set on wrap
  always_comb begin
    w_hi = '0;
    for (int c = 0; c < NCH; c++) begin
      w_hi[c] = wbck_i_valid[c] & (PW'(c) >= r_ptr);
    end
    w_req = (|w_hi) ? w_hi : wbck_i_valid;
  end

  // Encode the one-hot grant to an index for the pointer update
  always_comb begin
    w_gnt_idx = '0;
    for (int c = 0; c < NCH; c++) begin
      if (w_gnt_oh[c]) begin
        w_gnt_idx = PW'(c);
      end
    end
  end

  // Pointer moves just past the granted channel on every accept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_acc) begin
      r_ptr <= (w_gnt_idx == PW'(NCH - 1)) ? '0 : w_gnt_idx + PW'(1);
    end
  end
`else
  assign w_req = wbck_i_valid;
`endif

  // Lowest-index request wins among the (possibly masked) request set
  always_comb begin
    w_gnt_oh = '0;
    w_found  = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      w_gnt_oh[c] = w_req[c] & ~w_found;
      w_found     = w_found | w_req[c];
    end
  end

  // Payload mux for the granted channel
  always_comb begin
    w_gnt_wdat  = '0;
    w_gnt_rdidx = '0;
    for (int c = 0; c < NCH; c++) begin
      if (w_gnt_oh[c]) begin
        w_gnt_wdat  = wbck_i_wdat[c*DW +: DW];
        w_gnt_rdidx = wbck_i_rdidx[c*AW +: AW];
      end
    end
  end

  assign w_gnt_nz     = |w_gnt_rdidx;
  assign wbck_i_ready = w_acc ? w_gnt_oh : '0;

  // Output stage: load on accept, drop x0 writes, hold while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_o_vld   <= 1'b0;
      r_o_wdat  <= '0;
      r_o_rdidx <= '0;
    end else if (w_free) begin
      r_o_vld <= w_acc & w_gnt_nz;
      if (w_acc & w_gnt_nz) begin
        r_o_wdat  <= w_gnt_wdat;
        r_o_rdidx <= w_gnt_rdidx;
      end
    end
  end

  assign rf_wbck_o_ena   = r_o_vld;
  assign rf_wbck_o_wdat  = r_o_wdat;
  assign rf_wbck_o_rdidx = r_o_rdidx;

endmodule
